// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter for the serial system bus.
// The owner keeps the bus for a whole transaction. A watchdog reclaims the
// bus from an owner that holds it for TIMEOUT cycles.
//
// Request/grant handshake: a master raises its request with a non-zero
// slave_sel and keeps the request high for the whole transaction. The grant
// (bus_grant / mX_grant) is the "ready" side. The transfer owns the bus for
// every cycle the grant is high. The grant drops one edge after the request
// falls, tx_done pulses, or the watchdog fires. At least one idle cycle
// always separates two owners.
module bus_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int TMO_W   = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       m1_request,
   input  logic       m2_request,
   input  logic [1:0] m1_slave_sel,
   input  logic [1:0] m2_slave_sel,
   input  logic       tx_done,
   output logic [1:0] bus_grant,
   output logic [1:0] slave_grant,
   output logic       m1_grant,
   output logic       m2_grant,
   output logic       timeout,
   output logic [1:0] state_dbg
);

   // State encoding doubles as the registered bus_grant value.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      OWN_M1 = 2'b01,
      OWN_M2 = 2'b10
   } state_t;

   // Watchdog compare value. It is only meaningful when the watchdog is enabled.
   localparam bit              WDOG_EN    = (TIMEOUT != 0);
   localparam int              TMO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_LAST_I[TMO_W-1:0];

   localparam logic OWNER_M1 = 1'b0;
   localparam logic OWNER_M2 = 1'b1;

   state_t           state;
   state_t           state_nxt;
   logic             last_owner;
   logic             last_owner_nxt;
   logic [1:0]       slave_grant_nxt;
   logic [TMO_W-1:0] hold_cnt;
   logic [TMO_W-1:0] hold_cnt_nxt;
   logic             timeout_nxt;

   logic             m1_elig;
   logic             m2_elig;
   logic             owner_req;
   logic             wdog_hit;
   logic             release_bus;

   // A request with no target slave stays pending and is never granted.
   assign m1_elig = m1_request && (m1_slave_sel != 2'b00);
   assign m2_elig = m2_request && (m2_slave_sel != 2'b00);

   // Release conditions evaluated against the current owner.
   assign owner_req   = (state == OWN_M1) ? m1_request : m2_request;
   assign wdog_hit    = WDOG_EN && (hold_cnt == TMO_LAST);
   assign release_bus = !owner_req || tx_done || wdog_hit;

   // Next-state, arbitration and hold-counter logic.
   always_comb begin
      state_nxt       = state;
      last_owner_nxt  = last_owner;
      slave_grant_nxt = slave_grant;
      hold_cnt_nxt    = hold_cnt;
      timeout_nxt     = 1'b0;
      case (state)
         IDLE: begin
            // tx_done is ignored here. On a tie, the master that did not own the bus last wins.
            slave_grant_nxt = 2'b00;
            hold_cnt_nxt    = '0;
            if (m1_elig && (!m2_elig || (last_owner == OWNER_M2))) begin
               state_nxt       = OWN_M1;
               last_owner_nxt  = OWNER_M1;
               slave_grant_nxt = m1_slave_sel;
            end else if (m2_elig) begin
               state_nxt       = OWN_M2;
               last_owner_nxt  = OWNER_M2;
               slave_grant_nxt = m2_slave_sel;
            end
         end
         OWN_M1, OWN_M2: begin
            // Changes to slave_sel and to the other master's request are ignored while the bus is owned.
            if (release_bus) begin
               state_nxt       = IDLE;
               slave_grant_nxt = 2'b00;
               hold_cnt_nxt    = '0;
               timeout_nxt     = wdog_hit;
            end else if (hold_cnt != {TMO_W{1'b1}}) begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt       = IDLE;
            slave_grant_nxt = 2'b00;
            hold_cnt_nxt    = '0;
         end
      endcase
   end

   // State and output registers. Reset drops any grant at once and leaves M1 winning the next tie.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         last_owner  <= OWNER_M2;
         slave_grant <= 2'b00;
         hold_cnt    <= '0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         last_owner  <= last_owner_nxt;
         slave_grant <= slave_grant_nxt;
         hold_cnt    <= hold_cnt_nxt;
         timeout     <= timeout_nxt;
      end
   end

   assign bus_grant = state;
   assign m1_grant  = state[0];
   assign m2_grant  = state[1];
   assign state_dbg = state;

endmodule
